// File: rtl/fsm_slave.sv
// fsm_slave -- I2C slave protocol engine.
//
// Oversamples the bus SCL/SDA on the system clock, detects START/STOP,
// matches a 7-bit address, ACKs the master, collects write bytes and
// serves read bytes MSB-first. SDA is driven through sda_out/sda_oe;
// the pad-level mux outside this block turns that into the actual bus.
//
// Ports:
//   clk        system clock, at least 8x the SCL frequency
//   rst_       asynchronous active-low reset
//   scl_in     bus SCL
//   sda_in     bus SDA as seen at the pad
//   tx_data    byte returned on a read, latched on the tx_req clock
//   sda_out    value for SDA while sda_oe=1
//   sda_oe     1 = slave drives SDA, 0 = released
//   rx_data    last byte received in a write transfer
//   rx_valid   1-clk pulse when rx_data updates
//   tx_req     1-clk pulse on the clock where tx_data is latched
//   addr_match high from address ACK until STOP/START
//   busy       high from START to STOP
module fsm_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'b1011010,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic [7:0] tx_data,
  output logic       sda_out,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       addr_match,
  output logic       busy
);

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    WAIT_STOP
  } state_t;

  state_t              state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                scl_q;
  logic                sda_q;
  logic                scl_s;
  logic                sda_s;
  logic                scl_rise;
  logic                scl_fall;
  logic                start_det;
  logic                stop_det;
  logic [3:0]          cnt;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   shift_in;
  logic [DATA_W-1:0]   txbuf;
  logic                rw;
  logic                mack;

  // Stage p0: synchroniser chain plus one history flop per line.
  // The chain resets to 1 so an idle bus never looks like an edge.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      if (SYNC_STAGES > 1) begin
        scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
        sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      end else begin
        scl_sync <= scl_in;
        sda_sync <= sda_in;
      end
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  end

  // Stage p1: bus events, decoded from the synchronised and history values.
  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  // SDA may only move while SCL is low; a move with SCL held high across
  // both samples is a bus condition rather than data.
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign shift_in  = {shreg[DATA_W-2:0], sda_s};

  // Stage p2: protocol state machine with registered outputs.
  // cnt counts scl rises within a 9-bit slot: 8 means the byte is in,
  // 9 means the ACK bit has been clocked. All SDA drive changes happen
  // on scl_fall so the line is stable whenever SCL is high.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      sda_out    <= 1'b1;
      sda_oe     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_req     <= 1'b0;
      addr_match <= 1'b0;
      busy       <= 1'b0;
      cnt        <= 4'd0;
      shreg      <= '0;
      txbuf      <= '0;
      rw         <= 1'b0;
      mack       <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (start_det) begin
        // Valid from any state, including a repeated START mid-transfer.
        state      <= ADDR;
        cnt        <= 4'd0;
        sda_oe     <= 1'b0;
        busy       <= 1'b1;
        addr_match <= 1'b0;
      end else if (stop_det) begin
        // Any partial byte in shreg is simply abandoned.
        state      <= IDLE;
        cnt        <= 4'd0;
        sda_oe     <= 1'b0;
        busy       <= 1'b0;
        addr_match <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end

          ADDR: begin
            if (scl_rise && cnt < 4'd8) begin
              shreg <= shift_in;
              cnt   <= cnt + 4'd1;
            end else if (scl_fall && cnt == 4'd8) begin
              if (shreg[DATA_W-1:1] == SLAVE_ADDR) begin
                sda_oe     <= 1'b1;
                sda_out    <= 1'b0;
                addr_match <= 1'b1;
                rw         <= shreg[0];
                state      <= ADDR_ACK;
              end else begin
                sda_oe <= 1'b0;
                state  <= WAIT_STOP;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_rise && cnt == 4'd8) begin
              cnt <= 4'd9;
            end else if (scl_fall && cnt == 4'd9) begin
              cnt <= 4'd0;
              if (rw) begin
                // Keep driving: the ACK low turns straight into data bit 7.
                tx_req  <= 1'b1;
                txbuf   <= tx_data;
                sda_out <= tx_data[DATA_W-1];
                state   <= READ;
              end else begin
                sda_oe  <= 1'b0;
                sda_out <= 1'b1;
                state   <= WRITE;
              end
            end
          end

          WRITE: begin
            if (scl_rise && cnt < 4'd8) begin
              shreg <= shift_in;
              cnt   <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                rx_data  <= shift_in;
                rx_valid <= 1'b1;
              end
            end else if (scl_fall && cnt == 4'd8) begin
              sda_oe  <= 1'b1;
              sda_out <= 1'b0;
              state   <= WRITE_ACK;
            end
          end

          WRITE_ACK: begin
            if (scl_rise && cnt == 4'd8) begin
              cnt <= 4'd9;
            end else if (scl_fall && cnt == 4'd9) begin
              cnt     <= 4'd0;
              sda_oe  <= 1'b0;
              sda_out <= 1'b1;
              state   <= WRITE;
            end
          end

          READ: begin
            if (scl_rise && cnt < 4'd8) begin
              cnt <= cnt + 4'd1;
            end else if (scl_fall && cnt == 4'd8) begin
              sda_oe  <= 1'b0;
              sda_out <= 1'b1;
              state   <= READ_ACK;
            end else if (scl_fall && cnt != 4'd0) begin
              // txbuf[7] was already on the wire; present the next bit.
              txbuf   <= {txbuf[DATA_W-2:0], 1'b0};
              sda_out <= txbuf[DATA_W-2];
            end
          end

          READ_ACK: begin
            if (scl_rise && cnt == 4'd8) begin
              cnt  <= 4'd9;
              mack <= sda_s;
            end else if (scl_fall && cnt == 4'd9) begin
              cnt <= 4'd0;
              if (!mack) begin
                tx_req  <= 1'b1;
                txbuf   <= tx_data;
                sda_out <= tx_data[DATA_W-1];
                sda_oe  <= 1'b1;
                state   <= READ;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end

          WAIT_STOP: begin
          end

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
